// File: rtl/uart_pkg.sv
// Shared UART constants, scheduler state encoding and a counter-width helper.
package uart_pkg;

  localparam int DELAY_FRAMES = 234;
  localparam int UART_BYTE_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    GAP  = 2'd2
  } sched_state_t;

  // Width of a counter that must hold 0..max_val; a disabled (zero) limit still gets 1 bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Requester-side byte streams plus the single TX-engine handshake of the scheduler.
interface uart_tx_scheduler_if #(
  parameter int N_REQ = 4
);

  logic [N_REQ-1:0]                      req_valid;
  logic [uart_pkg::UART_BYTE_W*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]                      req_last;
  logic [N_REQ-1:0]                      req_ready;
  logic                                  tx_valid;
  logic [uart_pkg::UART_BYTE_W-1:0]      tx_data;
  logic                                  tx_ready;

  modport slave (
    input  req_valid, req_data, req_last, tx_ready,
    output req_ready, tx_valid, tx_data
  );

  modport master (
    output req_valid, req_data, req_last, tx_ready,
    input  req_ready, tx_valid, tx_data
  );

endinterface

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational rotate-priority encoder: first asserted req at or above ptr, with wrap.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  logic found;

  assign any = |req;

  always_comb begin
    int idx;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        found   = 1'b1;
        gnt_idx = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Packet-granular round-robin scheduler sharing one UART TX engine among N_REQ
// byte-stream requesters, with a fixed inter-packet idle gap and stalled-owner release.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int  N_REQ          = 4,
  parameter int  GAP_CYCLES     = 2340,
  parameter int  TIMEOUT_CYCLES = 65535,
  localparam int IDW            = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  uart_tx_scheduler_if.slave bus,
  output logic [IDW-1:0]     grant_id,
  output logic               busy,
  output logic               abort_pulse
);

  localparam logic [1:0] ST_IDLE = 2'(IDLE);
  localparam logic [1:0] ST_XFER = 2'(XFER);
  localparam logic [1:0] ST_GAP  = 2'(GAP);
  localparam logic [1:0] ST_DONE = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
  localparam int         IDLE_W  = cnt_width(TIMEOUT_CYCLES);
  localparam int         GAP_W   = cnt_width(GAP_CYCLES);

  logic [1:0]             state_q, state_d;
  logic [IDW-1:0]         grant_q, grant_d;
  logic [IDW-1:0]         ptr_q, ptr_d;
  logic [IDLE_W-1:0]      idle_cnt_q, idle_cnt_d;
  logic [GAP_W-1:0]       gap_cnt_q, gap_cnt_d;
  logic [IDW-1:0]         arb_idx;
  logic                   arb_any;
  logic                   in_xfer, own_valid, own_last, fire, timed_out;
  logic [UART_BYTE_W-1:0] own_data;
  logic [N_REQ-1:0]       ready_vec;

  rr_arbiter #(.N(N_REQ), .IW(IDW)) u_arb (
    .req     (bus.req_valid),
    .ptr     (ptr_q),
    .gnt_idx (arb_idx),
    .any     (arb_any)
  );

  assign in_xfer   = (state_q == ST_XFER);
  assign own_valid = bus.req_valid[grant_q];
  assign own_last  = bus.req_last[grant_q];
  assign own_data  = bus.req_data[int'(grant_q)*UART_BYTE_W +: UART_BYTE_W];

  assign bus.tx_valid = in_xfer & own_valid;
  assign bus.tx_data  = in_xfer ? own_data : '0;

  // NOTE: every signal written in always_comb gets a default first, so no path infers a latch.
  always_comb begin
    ready_vec = '0;
    if (in_xfer) ready_vec[grant_q] = bus.tx_ready;
  end
  assign bus.req_ready = ready_vec;

  assign fire = bus.tx_valid & bus.tx_ready;

  // Expiry uses the registered count, so an owner returning on that very cycle still finishes.
  assign timed_out = (TIMEOUT_CYCLES != 0) && in_xfer && !fire &&
                     (idle_cnt_q == IDLE_W'(TIMEOUT_CYCLES));

  assign abort_pulse = timed_out;
  assign grant_id    = grant_q;
  assign busy        = (state_q != ST_IDLE);

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    ptr_d      = ptr_q;
    idle_cnt_d = idle_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          state_d    = ST_XFER;
          grant_d    = arb_idx;
          ptr_d      = (arb_idx == IDW'(N_REQ - 1)) ? '0 : arb_idx + 1'b1;
          idle_cnt_d = '0;
        end
      end
      ST_XFER: begin
        gap_cnt_d = '0;
        if (fire) begin
          idle_cnt_d = '0;
          if (own_last) state_d = ST_DONE;
        end else if (timed_out) begin
          state_d = ST_DONE;
        end else if (!own_valid && idle_cnt_q != IDLE_W'(TIMEOUT_CYCLES)) begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) begin
          state_d   = ST_IDLE;
          gap_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments here so every register samples pre-edge values together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      ptr_q      <= '0;
      idle_cnt_q <= '0;
      gap_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      ptr_q      <= ptr_d;
      idle_cnt_q <= idle_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: three instances cover the default, short-timeout
// and gap/timeout-disabled configurations with hand-computed expectations.
module tb_uart_tx_scheduler;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  uart_tx_scheduler_if #(.N_REQ(4)) ifa ();
  uart_tx_scheduler_if #(.N_REQ(4)) ifb ();
  uart_tx_scheduler_if #(.N_REQ(4)) ifc ();

  logic [1:0] gnt_a, gnt_b, gnt_c;
  logic       busy_a, busy_b, busy_c;
  logic       abort_a, abort_b, abort_c;

  uart_tx_scheduler #(.N_REQ(4), .GAP_CYCLES(2340), .TIMEOUT_CYCLES(65535)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa.slave),
    .grant_id(gnt_a), .busy(busy_a), .abort_pulse(abort_a));

  uart_tx_scheduler #(.N_REQ(4), .GAP_CYCLES(8), .TIMEOUT_CYCLES(100)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb.slave),
    .grant_id(gnt_b), .busy(busy_b), .abort_pulse(abort_b));

  uart_tx_scheduler #(.N_REQ(4), .GAP_CYCLES(0), .TIMEOUT_CYCLES(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .bus(ifc.slave),
    .grant_id(gnt_c), .busy(busy_c), .abort_pulse(abort_c));

  task automatic clear_inputs();
    ifa.req_valid = '0; ifa.req_data = '0; ifa.req_last = '0; ifa.tx_ready = 1'b0;
    ifb.req_valid = '0; ifb.req_data = '0; ifb.req_last = '0; ifb.tx_ready = 1'b0;
    ifc.req_valid = '0; ifc.req_data = '0; ifc.req_last = '0; ifc.tx_ready = 1'b0;
  endtask

  // Leaves the bench on a falling edge with rst_n just released.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({ifa.tx_valid, ifa.tx_data, ifa.req_ready, gnt_a, busy_a, abort_a} !== 17'h0) begin
      failures++;
      $display("FAIL reset_outputs_a: got %0h expected 0",
               {ifa.tx_valid, ifa.tx_data, ifa.req_ready, gnt_a, busy_a, abort_a});
    end
    checks++;
    if ({busy_b, busy_c, ifb.tx_valid, ifc.tx_valid, abort_b, abort_c} !== 6'h0) begin
      failures++;
      $display("FAIL reset_outputs_bc: got %0h expected 0",
               {busy_b, busy_c, ifb.tx_valid, ifc.tx_valid, abort_b, abort_c});
    end
    rst_n = 1'b1;
    ifa.req_valid = 4'b0001; ifa.req_data[7:0] = 8'h10; ifa.tx_ready = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (ifa.tx_valid !== 1'b1 || ifa.tx_data !== 8'h10) begin
      failures++;
      $display("FAIL reset_first_grant: got valid=%0b data=%0h expected valid=1 data=10",
               ifa.tx_valid, ifa.tx_data);
    end
    @(negedge clk); ifa.req_data[7:0] = 8'h11;
    @(negedge clk); ifa.req_data[7:0] = 8'h12;
    #1;
    checks++;
    if (ifa.tx_valid !== 1'b1 || ifa.tx_data !== 8'h12) begin
      failures++;
      $display("FAIL reset_byte2: got valid=%0b data=%0h expected valid=1 data=12",
               ifa.tx_valid, ifa.tx_data);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (ifa.tx_valid !== 1'b0 || busy_a !== 1'b0) begin
      failures++;
      $display("FAIL reset_async_drop: got valid=%0b busy=%0b expected 0 0", ifa.tx_valid, busy_a);
    end
    @(negedge clk);
    rst_n = 1'b1;
    ifa.req_data[7:0] = 8'h10;
    @(negedge clk); #1;
    checks++;
    if (ifa.tx_valid !== 1'b1 || gnt_a !== 2'd0 || ifa.tx_data !== 8'h10) begin
      failures++;
      $display("FAIL reset_regrant: got valid=%0b grant=%0d data=%0h expected 1 0 10",
               ifa.tx_valid, gnt_a, ifa.tx_data);
    end
  endtask

  task automatic test_single_packet();
    logic [7:0] msg [3];
    int busy_cnt;
    int gap_valid;
    msg = '{8'h48, 8'h49, 8'h0A};
    busy_cnt  = 0;
    gap_valid = 0;
    do_reset();
    ifa.tx_ready = 1'b1;
    ifa.req_valid[1] = 1'b1; ifa.req_data[15:8] = msg[0];
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      ifa.req_data[15:8] = msg[i];
      ifa.req_last[1]    = (i == 2);
      #1;
      checks++;
      if (ifa.tx_valid !== 1'b1 || ifa.tx_data !== msg[i] || gnt_a !== 2'd1 ||
          ifa.req_ready !== 4'b0010) begin
        failures++;
        $display("FAIL single_byte%0d: got valid=%0b data=%0h grant=%0d ready=%0b expected 1 %0h 1 0010",
                 i, ifa.tx_valid, ifa.tx_data, gnt_a, ifa.req_ready, msg[i]);
      end
      @(negedge clk);
    end
    ifa.req_valid = '0; ifa.req_last = '0;
    while (busy_cnt < 3000) begin
      #1;
      if (!busy_a) break;
      if (ifa.tx_valid) gap_valid++;
      busy_cnt++;
      @(negedge clk);
    end
    checks++;
    if (busy_cnt != 2340 || gap_valid != 0) begin
      failures++;
      $display("FAIL single_gap: got busy_cycles=%0d gap_valid=%0d expected 2340 0", busy_cnt, gap_valid);
    end
    checks++;
    if (gnt_a !== 2'd1) begin
      failures++;
      $display("FAIL single_grant_hold: got %0d expected 1", gnt_a);
    end
  endtask

  task automatic test_contention();
    int bidx [4];
    int exp_order [5];
    int pkt;
    int owner;
    int cyc;
    logic [7:0] exp_data;
    exp_order = '{0, 1, 2, 3, 0};
    pkt = 0;
    cyc = 0;
    foreach (bidx[i]) bidx[i] = 0;
    do_reset();
    ifa.tx_ready = 1'b1;
    while (pkt < 5 && cyc < 12500) begin
      for (int i = 0; i < 4; i++) begin
        ifa.req_valid[i]       = 1'b1;
        ifa.req_data[i*8 +: 8] = {4'(i), 4'(bidx[i])};
        ifa.req_last[i]        = (bidx[i] == 1);
      end
      #1;
      if (ifa.tx_valid && ifa.tx_ready) begin
        owner    = exp_order[pkt];
        exp_data = {4'(owner), 4'(bidx[owner])};
        checks++;
        if (gnt_a !== 2'(owner) || ifa.tx_data !== exp_data || ifa.req_ready !== 4'(1 << owner)) begin
          failures++;
          $display("FAIL contention_pkt%0d: got grant=%0d data=%0h ready=%0b expected %0d %0h %0b",
                   pkt, gnt_a, ifa.tx_data, ifa.req_ready, owner, exp_data, 4'(1 << owner));
        end
        if (bidx[owner] == 1) begin
          bidx[owner] = 0;
          pkt++;
        end else begin
          bidx[owner] = 1;
        end
      end
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (pkt != 5) begin
      failures++;
      $display("FAIL contention_done: got packets=%0d expected 5", pkt);
    end
    clear_inputs();
  endtask

  task automatic test_backpressure();
    logic [7:0] msg [3];
    int bi, cyc, mism, aborts;
    logic rdy;
    logic [3:0] exp_rdy;
    msg = '{8'h31, 8'h32, 8'h33};
    bi = 0; cyc = 0; mism = 0; aborts = 0;
    do_reset();
    while (bi < 3 && cyc < 1000) begin
      rdy = ((cyc % 234) == 233);
      ifb.req_valid[0]  = 1'b1;
      ifb.req_data[7:0] = msg[bi];
      ifb.req_last[0]   = (bi == 2);
      ifb.tx_ready      = rdy;
      #1;
      exp_rdy = (cyc > 0) ? {3'b000, rdy} : 4'b0000;
      if (ifb.req_ready !== exp_rdy || ifb.tx_valid !== (cyc > 0)) mism++;
      if (abort_b) aborts++;
      if (ifb.tx_valid && ifb.tx_ready) begin
        checks++;
        if (ifb.tx_data !== msg[bi]) begin
          failures++;
          $display("FAIL bp_byte%0d: got %0h expected %0h", bi, ifb.tx_data, msg[bi]);
        end
        bi++;
      end
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (bi != 3 || cyc != 702) begin
      failures++;
      $display("FAIL bp_accept: got bytes=%0d cycles=%0d expected 3 702", bi, cyc);
    end
    checks++;
    if (mism != 0 || aborts != 0) begin
      failures++;
      $display("FAIL bp_mirror: got ready_mismatches=%0d aborts=%0d expected 0 0", mism, aborts);
    end
    clear_inputs();
  endtask

  task automatic test_timeout();
    int aborts, abort_at, grant3_at;
    aborts = 0; abort_at = -1; grant3_at = -1;
    do_reset();
    ifb.tx_ready = 1'b1;
    ifb.req_valid = 4'b1100;
    ifb.req_data[23:16] = 8'hAA;
    ifb.req_data[31:24] = 8'h3C;
    ifb.req_last = 4'b1000;
    @(negedge clk); #1;
    checks++;
    if (gnt_b !== 2'd2 || ifb.tx_valid !== 1'b1 || ifb.tx_data !== 8'hAA) begin
      failures++;
      $display("FAIL to_grant2: got grant=%0d valid=%0b data=%0h expected 2 1 aa",
               gnt_b, ifb.tx_valid, ifb.tx_data);
    end
    @(negedge clk);
    ifb.req_valid[2] = 1'b0;
    for (int c = 0; c < 130; c++) begin
      #1;
      if (abort_b) begin
        aborts++;
        if (abort_at < 0) abort_at = c;
      end
      if (c == 101) begin
        checks++;
        if (busy_b !== 1'b1 || ifb.tx_valid !== 1'b0) begin
          failures++;
          $display("FAIL to_gap: got busy=%0b valid=%0b expected 1 0", busy_b, ifb.tx_valid);
        end
      end
      if (grant3_at < 0 && ifb.tx_valid && gnt_b == 2'd3) begin
        grant3_at = c;
        checks++;
        if (ifb.tx_data !== 8'h3C) begin
          failures++;
          $display("FAIL to_next_data: got %0h expected 3c", ifb.tx_data);
        end
      end
      @(negedge clk);
      if (grant3_at >= 0) ifb.req_valid[3] = 1'b0;
    end
    checks++;
    if (aborts != 1 || abort_at != 100) begin
      failures++;
      $display("FAIL to_abort: got pulses=%0d at=%0d expected 1 100", aborts, abort_at);
    end
    checks++;
    if (grant3_at != 110) begin
      failures++;
      $display("FAIL to_next_grant: got %0d expected 110", grant3_at);
    end
    clear_inputs();
  endtask

  task automatic test_edge();
    int aborts, not_busy;
    aborts = 0; not_busy = 0;
    do_reset();
    ifc.tx_ready = 1'b1;
    ifc.req_valid = 4'b0110;
    ifc.req_data[15:8]  = 8'h11;
    ifc.req_data[23:16] = 8'h22;
    ifc.req_last = 4'b0100;
    @(negedge clk); #1;
    checks++;
    if (gnt_c !== 2'd1 || ifc.tx_valid !== 1'b1 || ifc.tx_data !== 8'h11) begin
      failures++;
      $display("FAIL edge_grant1: got grant=%0d valid=%0b data=%0h expected 1 1 11",
               gnt_c, ifc.tx_valid, ifc.tx_data);
    end
    @(negedge clk);
    ifc.req_valid[1] = 1'b0;
    repeat (150) begin
      #1;
      if (abort_c) aborts++;
      if (busy_c !== 1'b1) not_busy++;
      @(negedge clk);
    end
    checks++;
    if (aborts != 0 || not_busy != 0 || gnt_c !== 2'd1) begin
      failures++;
      $display("FAIL edge_no_timeout: got aborts=%0d not_busy=%0d grant=%0d expected 0 0 1",
               aborts, not_busy, gnt_c);
    end
    ifc.req_valid[1] = 1'b1; ifc.req_data[15:8] = 8'h1F; ifc.req_last[1] = 1'b1;
    #1;
    checks++;
    if (ifc.tx_valid !== 1'b1 || ifc.tx_data !== 8'h1F || abort_c !== 1'b0) begin
      failures++;
      $display("FAIL edge_last: got valid=%0b data=%0h abort=%0b expected 1 1f 0",
               ifc.tx_valid, ifc.tx_data, abort_c);
    end
    @(negedge clk);
    ifc.req_valid[1] = 1'b0; ifc.req_last[1] = 1'b0;
    #1;
    checks++;
    if (busy_c !== 1'b0 || ifc.tx_valid !== 1'b0) begin
      failures++;
      $display("FAIL edge_direct_idle: got busy=%0b valid=%0b expected 0 0", busy_c, ifc.tx_valid);
    end
    @(negedge clk); #1;
    checks++;
    if (gnt_c !== 2'd2 || ifc.tx_valid !== 1'b1 || ifc.tx_data !== 8'h22) begin
      failures++;
      $display("FAIL edge_grant2: got grant=%0d valid=%0b data=%0h expected 2 1 22",
               gnt_c, ifc.tx_valid, ifc.tx_data);
    end
    @(negedge clk);
    ifc.req_valid[2] = 1'b0;
    ifc.req_valid[1] = 1'b1; ifc.req_data[15:8] = 8'h1E; ifc.req_last[1] = 1'b1;
    #1;
    checks++;
    if (busy_c !== 1'b0) begin
      failures++;
      $display("FAIL edge_idle2: got busy=%0b expected 0", busy_c);
    end
    @(negedge clk); #1;
    checks++;
    if (gnt_c !== 2'd1 || ifc.tx_data !== 8'h1E) begin
      failures++;
      $display("FAIL edge_regrant1: got grant=%0d data=%0h expected 1 1e", gnt_c, ifc.tx_data);
    end
    @(negedge clk);
    clear_inputs();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "bench time limit expired");
  end

  initial begin
    test_reset();
    test_single_packet();
    test_contention();
    test_backpressure();
    test_timeout();
    test_edge();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
